semafor_ctrl: RTL and testbench

Traffic-light controller for one car signal and one pedestrian crossing. It divides the system clock into a one-second-style tick and steps a Moore state machine through timed car and pedestrian phases. It latches pedestrian requests and supports a night mode with a blinking car yellow. It sits between the board push-button/switch inputs and the lamp drivers, and is clocked and reset by the common clock/reset source.

---
 rtl/semafor_pkg.sv | 53 +++++
 rtl/semafor_tick_gen.sv | 28 ++
 rtl/semafor_ctrl.sv | 116 +++++++++++
 tb/tb_semafor_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/semafor_pkg.sv
// Shared state encoding, default timing and lamp decode for the semafor traffic-light controller.
package semafor_pkg;

    localparam logic [2:0] ALL_RED    = 3'd0;
    localparam logic [2:0] CAR_GREEN  = 3'd1;
    localparam logic [2:0] CAR_YELLOW = 3'd2;
    localparam logic [2:0] PED_GREEN  = 3'd3;
    localparam logic [2:0] PED_CLEAR  = 3'd4;
    localparam logic [2:0] NIGHT      = 3'd5;

    typedef enum logic [2:0] {
        StAllRed    = ALL_RED,
        StCarGreen  = CAR_GREEN,
        StCarYellow = CAR_YELLOW,
        StPedGreen  = PED_GREEN,
        StPedClear  = PED_CLEAR,
        StNight     = NIGHT
    } state_e;

    localparam int unsigned DefTickDiv = 4;
    localparam int unsigned DefTGreen  = 6;
    localparam int unsigned DefTYellow = 2;
    localparam int unsigned DefTAllRed = 1;
    localparam int unsigned DefTPed    = 4;
    localparam int unsigned DefTClear  = 2;
    localparam int unsigned DefCntW    = 8;

    typedef struct packed {
        logic car_red;
        logic car_yel;
        logic car_grn;
        logic ped_red;
        logic ped_grn;
    } lamps_t;

    localparam lamps_t LampsReset = '{car_red: 1'b1, car_yel: 1'b0, car_grn: 1'b0,
                                      ped_red: 1'b1, ped_grn: 1'b0};

    function automatic lamps_t lamps_for(input state_e st, input logic blink);
        lamps_t l;
        l = '0;
        case (st)
            StCarGreen:  begin l.car_grn = 1'b1; l.ped_red = 1'b1; end
            StCarYellow: begin l.car_yel = 1'b1; l.ped_red = 1'b1; end
            StPedGreen:  begin l.car_red = 1'b1; l.ped_grn = 1'b1; end
            StPedClear:  begin l.car_red = 1'b1; l.ped_grn = blink; end
            StNight:     l.car_yel = blink;
            default:     begin l.car_red = 1'b1; l.ped_red = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/semafor_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV clocks (permanently high when TICK_DIV is 1).
module semafor_tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned PreW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

    logic [PreW-1:0] pre_q, pre_d;

    always_comb begin
        tick  = (pre_q == PreLast);
        pre_d = tick ? '0 : pre_q + PreW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/semafor_ctrl.sv
// Car/pedestrian traffic-light controller: timed Moore FSM, latched pedestrian request,
// blinking night mode and registered lamp drivers.
module semafor_ctrl
    import semafor_pkg::*;
#(
    parameter int unsigned TICK_DIV = DefTickDiv,
    parameter int unsigned T_GREEN  = DefTGreen,
    parameter int unsigned T_YELLOW = DefTYellow,
    parameter int unsigned T_ALLRED = DefTAllRed,
    parameter int unsigned T_PED    = DefTPed,
    parameter int unsigned T_CLEAR  = DefTClear,
    parameter int unsigned CNT_W    = DefCntW
) (
    input  logic clk,
    input  logic rst,
    input  logic ped_req,
    input  logic night_mode,
    output logic car_red,
    output logic car_yel,
    output logic car_grn,
    output logic ped_red,
    output logic ped_grn,
    output logic ped_ack
);

    localparam logic [CNT_W-1:0] GreenLast  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] YellowLast = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AllRedLast = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] PedLast    = CNT_W'(T_PED - 1);
    localparam logic [CNT_W-1:0] ClearLast  = CNT_W'(T_CLEAR - 1);

    logic             tick;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] tim_q, tim_d;
    logic             ped_pend_q, ped_pend_d;
    logic             blink_q, blink_d;
    lamps_t           lamps_q, lamps_d;
    logic             changing, blinking_q, blinking_d, green_sat;

    semafor_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StAllRed:    if (tick && tim_q == AllRedLast)
                             state_d = ped_pend_q ? StPedGreen : StCarGreen;
            // Night is checked first; both exits pass through yellow.
            StCarGreen:  if (tick && tim_q == GreenLast && (night_mode || ped_pend_q))
                             state_d = StCarYellow;
            StCarYellow: if (tick && tim_q == YellowLast)
                             state_d = night_mode ? StNight : StAllRed;
            StPedGreen:  if (tick && tim_q == PedLast) state_d = StPedClear;
            StPedClear:  if (tick && tim_q == ClearLast) state_d = StCarGreen;
            StNight:     if (tick && !night_mode) state_d = StAllRed;
            default:     state_d = StAllRed;
        endcase

        changing   = (state_d != state_q);
        green_sat  = (state_q == StCarGreen) && (tim_q == GreenLast);
        blinking_q = (state_q == StNight) || (state_q == StPedClear);
        blinking_d = (state_d == StNight) || (state_d == StPedClear);

        tim_d = tim_q;
        if (changing) begin
            tim_d = '0;
        end else if (tick && !green_sat) begin
            tim_d = tim_q + CNT_W'(1);
        end

        // Entering PED_GREEN serves the request and overrides a same-cycle press.
        if (changing && state_d == StPedGreen) begin
            ped_pend_d = 1'b0;
        end else begin
            ped_pend_d = ped_pend_q | ped_req;
        end

        blink_d = blink_q;
        if (changing && blinking_d) begin
            blink_d = 1'b1;
        end else if (!changing && tick && blinking_q) begin
            blink_d = ~blink_q;
        end

        lamps_d = lamps_for(state_d, blink_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StAllRed;
            tim_q      <= '0;
            ped_pend_q <= 1'b0;
            blink_q    <= 1'b0;
            lamps_q    <= LampsReset;
        end else begin
            state_q    <= state_d;
            tim_q      <= tim_d;
            ped_pend_q <= ped_pend_d;
            blink_q    <= blink_d;
            lamps_q    <= lamps_d;
        end
    end

    assign car_red = lamps_q.car_red;
    assign car_yel = lamps_q.car_yel;
    assign car_grn = lamps_q.car_grn;
    assign ped_red = lamps_q.ped_red;
    assign ped_grn = lamps_q.ped_grn;
    assign ped_ack = ped_pend_q;

endmodule

// File: tb/tb_semafor_ctrl.sv
// Directed bench for semafor_ctrl with default timing (4 clk per tick), plus a random safety soak.
module tb_semafor_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ped_req = 1'b0;
    logic night_mode = 1'b0;
    logic car_red, car_yel, car_grn, ped_red, ped_grn, ped_ack;

    int vectors = 0;
    int errors  = 0;

    // {car_red, car_yel, car_grn, ped_red, ped_grn}
    localparam logic [4:0] LAllRed = 5'b10010;
    localparam logic [4:0] LGreen  = 5'b00110;
    localparam logic [4:0] LYellow = 5'b01010;
    localparam logic [4:0] LPedG   = 5'b10001;
    localparam logic [4:0] LPedOff = 5'b10000;
    localparam logic [4:0] LNightY = 5'b01000;
    localparam logic [4:0] LDark   = 5'b00000;

    semafor_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .ped_req    (ped_req),
        .night_mode (night_mode),
        .car_red    (car_red),
        .car_yel    (car_yel),
        .car_grn    (car_grn),
        .ped_red    (ped_red),
        .ped_grn    (ped_grn),
        .ped_ack    (ped_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b, expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [4:0] l, input logic a);
        check_eq(tag, {2'b00, ped_ack, car_red, car_yel, car_grn, ped_red, ped_grn},
                 {2'b00, a, l});
    endtask

    // n clock edges, checking lamps and ack 1 ns after each.
    task automatic expect_for(input string tag, input int n, input logic [4:0] l, input logic a);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_state(tag, l, a);
        end
    endtask

    // Leaves the bench just before edge 1 after release; ALL_RED expires at edge 4.
    task automatic do_reset();
        ped_req    = 1'b0;
        night_mode = 1'b0;
        rst        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset_hold", LAllRed, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_state("reset_release", LAllRed, 1'b0);
    endtask

    // Reset, green at edge 4, one-cycle press sampled at edge 6, run through edge 39 (ALL_RED).
    task automatic to_allred_with_req();
        do_reset();
        expect_for("ar0", 3, LAllRed, 1'b0);
        expect_for("grn_entry", 2, LGreen, 1'b0);
        ped_req = 1'b1;
        expect_for("grn_req", 1, LGreen, 1'b1);
        ped_req = 1'b0;
        expect_for("grn_pend", 21, LGreen, 1'b1);
        expect_for("yel", 8, LYellow, 1'b1);
        expect_for("ar1", 4, LAllRed, 1'b1);
    endtask

    logic prev_grn;

    initial begin
        #2;
        // Idle: 4 cycles ALL_RED then green forever.
        do_reset();
        expect_for("idle_allred", 3, LAllRed, 1'b0);
        expect_for("idle_green", 110, LGreen, 1'b0);

        // Full pedestrian cycle.
        to_allred_with_req();
        expect_for("pedg", 16, LPedG, 1'b0);
        expect_for("pedc_on", 4, LPedG, 1'b0);
        expect_for("pedc_off", 4, LPedOff, 1'b0);
        expect_for("grn_back", 30, LGreen, 1'b0);

        // Press held on the PED_GREEN entry edge is dropped, next cycle's press latches.
        to_allred_with_req();
        ped_req = 1'b1;
        expect_for("clr_wins", 1, LPedG, 1'b0);
        expect_for("relatch", 1, LPedG, 1'b1);
        ped_req = 1'b0;
        expect_for("pedg2", 14, LPedG, 1'b1);
        expect_for("pedc2_on", 4, LPedG, 1'b1);
        expect_for("pedc2_off", 4, LPedOff, 1'b1);
        expect_for("grn2", 24, LGreen, 1'b1);
        expect_for("yel2", 8, LYellow, 1'b1);
        expect_for("ar2", 4, LAllRed, 1'b1);
        expect_for("served2", 1, LPedG, 1'b0);
        // Async reset mid-PED_GREEN with a pending request.
        ped_req = 1'b1;
        expect_for("pedg_repress", 1, LPedG, 1'b1);
        ped_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_state("async_rst", LAllRed, 1'b0);
        #1;
        rst = 1'b0;

        // Night and request together after minimum green.
        do_reset();
        expect_for("n_ar", 3, LAllRed, 1'b0);
        expect_for("n_grn", 22, LGreen, 1'b0);
        night_mode = 1'b1;
        ped_req    = 1'b1;
        expect_for("n_grn_req", 1, LGreen, 1'b1);
        ped_req = 1'b0;
        expect_for("n_grn_last", 1, LGreen, 1'b1);
        expect_for("n_yel", 8, LYellow, 1'b1);
        expect_for("night_on", 4, LNightY, 1'b1);
        expect_for("night_off", 4, LDark, 1'b1);
        expect_for("night_on2", 4, LNightY, 1'b1);
        expect_for("night_off2", 2, LDark, 1'b1);
        night_mode = 1'b0;
        expect_for("night_exit", 2, LDark, 1'b1);
        expect_for("n_ar_exit", 4, LAllRed, 1'b1);
        expect_for("n_pedg", 2, LPedG, 1'b0);

        // Random soak: no green conflict, no direct green-to-red.
        do_reset();
        prev_grn = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 299) == 0) night_mode = ~night_mode;
            ped_req = ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
            check_eq("no_conflict", {7'b0, car_grn & ped_grn}, 8'd0);
            check_eq("yel_before_red", {7'b0, prev_grn & car_red}, 8'd0);
            prev_grn = car_grn;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
